icache_dm: RTL

- Direct-mapped, read-only instruction cache: the responder on the fetch stage's instruction port (address in; instruction and valid out).
- On a hit it returns the 32-bit instruction one cycle after the address is sampled.
- On a miss it stalls (valid=0) and refills the whole line word-by-word from a backing memory port, one outstanding request at a time.
- Drop-in replacement for the fixed-delay icache model under fetch.

---
 rtl/icache_pkg.sv | 27 ++
 rtl/icache_refill_fsm.sv | 111 +++++++++++
 rtl/icache_dm.sv | 126 ++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared types and address-split helpers for the direct-mapped
// instruction cache.
//   icache_state_e  refill controller state (LOOKUP / REQ / WAIT)
//   off_bits()      byte-offset bits inside one line
//   idx_bits()      line-index bits
//   tag_bits()      remaining upper address bits stored as the tag
package icache_pkg;

  typedef enum logic [1:0] {
    LOOKUP = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2
  } icache_state_e;

  function automatic int off_bits(input int words_per_line);
    return $clog2(words_per_line * 4);
  endfunction

  function automatic int idx_bits(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_bits(input int lines, input int words_per_line);
    return 32 - off_bits(words_per_line) - idx_bits(lines);
  endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// icache_refill_fsm: line refill controller for icache_dm.
// Owns the LOOKUP/REQ/WAIT state, the word counter, the latched line base
// address and the backing-memory request handshake.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start_i             miss detected in LOOKUP at this edge
//   start_addr_i        fetch address of the miss (offset bits dropped)
//   mem_req_valid_o     word read request (held until accepted)
//   mem_req_addr_o      word-aligned request address, stable while valid
//   mem_req_ready_i     memory accepts the request at this edge
//   mem_resp_valid_i    read data returned (one per accepted request)
//   wr_en_o             write the returned word into the line
//   wr_word_o           word index inside the line for wr_en_o
//   line_done_o         last word of the line is being written
//   state_o             current controller state (observable)
//   base_o              latched line base address of the refill
//
// Handshake: a request transfers at a rising edge where mem_req_valid_o and
// mem_req_ready_i are both 1. Until then valid stays high and the address
// does not change. Exactly one request is outstanding: the next request is
// raised only in the cycle after the matching response has been consumed.
module icache_refill_fsm
  import icache_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_i,
  input  logic [31:0]                          start_addr_i,
  output logic                                 mem_req_valid_o,
  output logic [31:0]                          mem_req_addr_o,
  input  logic                                 mem_req_ready_i,
  input  logic                                 mem_resp_valid_i,
  output logic                                 wr_en_o,
  output logic [off_bits(WORDS_PER_LINE)-3:0]  wr_word_o,
  output logic                                 line_done_o,
  output icache_state_e                        state_o,
  output logic [31:0]                          base_o
);

  localparam int OFF = off_bits(WORDS_PER_LINE);
  localparam int WB  = OFF - 2;
  localparam logic [WB-1:0] LAST = WB'(WORDS_PER_LINE - 1);

  icache_state_e state_q, state_d;
  logic [WB-1:0] cnt_q, cnt_d;
  logic [31:0]   base_q, base_d;
  logic          unused_start_off;

  // Offset bits of the miss address are cleared when the base is latched.
  assign unused_start_off = ^start_addr_i[OFF-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    case (state_q)
      LOOKUP: begin
        if (start_i) begin
          state_d = REQ;
          cnt_d   = '0;
          base_d  = {start_addr_i[31:OFF], {OFF{1'b0}}};
        end
      end
      REQ: begin
        if (mem_req_ready_i) state_d = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid_i) begin
          if (cnt_q == LAST) begin
            state_d = LOOKUP;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = REQ;
          end
        end
      end
      default: state_d = LOOKUP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOOKUP;
      cnt_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
    end
  end

  // Request address is base + 4*counter; with base and counter both reset
  // to zero it reads 0 out of reset.
  assign mem_req_valid_o = (state_q == REQ);
  assign mem_req_addr_o  = {base_q[31:OFF], cnt_q, 2'b00};

  // Responses outside WAIT are dropped here: they never reach the arrays.
  assign wr_en_o     = (state_q == WAIT) && mem_resp_valid_i;
  assign wr_word_o   = cnt_q;
  assign line_done_o = wr_en_o && (cnt_q == LAST);
  assign state_o     = state_q;
  assign base_o      = base_q;

  resp_only_in_wait: assert property (
    @(posedge clk) disable iff (rst) mem_resp_valid_i |-> (state_q == WAIT)
  );

endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache in front of a
// word-wide backing memory. Hits return the instruction one cycle after the
// address is sampled; misses stall (valid=0) while the whole line is
// refilled word by word.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   address          fetch byte address (bits [1:0] ignored)
//   instruction      instruction word for the last sampled address
//   valid            instruction is valid for the address of the last edge
//   invalidate       one-cycle pulse clearing every line valid bit
//   mem_req_valid    word read request to backing memory
//   mem_req_addr     word-aligned request address
//   mem_req_ready    memory accepts the request at this edge
//   mem_resp_valid   read data returned
//   mem_resp_data    read data
module icache_dm
  import icache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  output logic [31:0] instruction,
  output logic        valid,
  input  logic        invalidate,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int OFF = off_bits(WORDS_PER_LINE);
  localparam int IDX = idx_bits(LINES);
  localparam int TAG = tag_bits(LINES, WORDS_PER_LINE);
  localparam int WB  = OFF - 2;

  // Line storage: valid bits are reset, tags and data are not.
  logic [LINES-1:0] lv_q;
  logic [TAG-1:0]   tag_q  [LINES];
  logic [31:0]      data_q [LINES][WORDS_PER_LINE];

  logic        valid_q, valid_d;
  logic [31:0] instr_q;
  logic        inv_pend_q;

  icache_state_e fsm_state;
  logic [31:0]   base;
  logic          wr_en, line_done;
  logic [WB-1:0] wr_word;

  logic [IDX-1:0] a_idx, w_idx;
  logic [TAG-1:0] a_tag, w_tag;
  logic [WB-1:0]  a_word;
  logic           in_lookup, hit, miss;
  logic           unused_bits;

  assign unused_bits = ^{address[1:0], base[OFF-1:0]};

  assign a_word = address[OFF-1:2];
  assign a_idx  = address[OFF+IDX-1:OFF];
  assign a_tag  = address[31:OFF+IDX];
  assign w_idx  = base[OFF+IDX-1:OFF];
  assign w_tag  = base[31:OFF+IDX];

  assign in_lookup = (fsm_state == LOOKUP);
  assign hit       = lv_q[a_idx] && (tag_q[a_idx] == a_tag);
  // A hit that coincides with invalidate reports valid=0 but does not start
  // a refill: the line is gone, so the next sample of the address misses.
  assign miss      = in_lookup && !hit;
  assign valid_d   = in_lookup && hit && !invalidate;

  icache_refill_fsm #(
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_refill (
    .clk              (clk),
    .rst              (reset),
    .start_i          (miss),
    .start_addr_i     (address),
    .mem_req_valid_o  (mem_req_valid),
    .mem_req_addr_o   (mem_req_addr),
    .mem_req_ready_i  (mem_req_ready),
    .mem_resp_valid_i (mem_resp_valid),
    .wr_en_o          (wr_en),
    .wr_word_o        (wr_word),
    .line_done_o      (line_done),
    .state_o          (fsm_state),
    .base_o           (base)
  );

  always_ff @(posedge clk) begin
    if (wr_en)     data_q[w_idx][wr_word] <= mem_resp_data;
    if (line_done) tag_q[w_idx]           <= w_tag;
  end

  // An invalidate seen while a refill is in flight is remembered so the
  // line being filled is not published as valid when it completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lv_q       <= '0;
      inv_pend_q <= 1'b0;
    end else begin
      if (invalidate)     lv_q        <= '0;
      else if (line_done) lv_q[w_idx] <= !inv_pend_q;

      if (line_done)                     inv_pend_q <= 1'b0;
      else if (invalidate && !in_lookup) inv_pend_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (valid_d) instr_q <= data_q[a_idx][a_word];
    end
  end

  assign valid       = valid_q;
  assign instruction = instr_q;

endmodule
